// File: rtl/fifo_pack_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pack_pkg
//
// Shared definitions for the FIFO read-side packer.
//
// Contents:
//   DEF_DATA_W      default FIFO word width
//   DEF_PACK_WORDS  default number of words per packet (legal 2..8)
//   pack_state_e    packer FSM state (FILL collects words, SEND offers packet)
// -----------------------------------------------------------------------------
package fifo_pack_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_PACK_WORDS = 2;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } pack_state_e;

endpackage : fifo_pack_pkg

// File: rtl/fifo_pack_chk.sv
// -----------------------------------------------------------------------------
// fifo_pack_chk
//
// XOR checksum accumulator for the packet being assembled. Each captured word
// is folded in; the sum clears when the packet is handed downstream.
//
// Ports:
//   clk_b    in   read-domain clock
//   rst      in   synchronous active-high reset
//   clear    in   packet accepted downstream; restart the sum
//   capture  in   word on 'word' is being stored into the packet this cycle
//   word     in   [DATA_W-1:0] captured FIFO word
//   chk      out  [DATA_W-1:0] running XOR of captured words
// -----------------------------------------------------------------------------
module fifo_pack_chk #(
  parameter int DATA_W = 16
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] chk
);

  always_ff @(posedge clk_b) begin
    if (rst || clear) begin
      chk <= '0;
    end else if (capture) begin
      chk <= chk ^ word;
    end
  end

endmodule : fifo_pack_chk

// File: rtl/fifo_pack_reader.sv
// -----------------------------------------------------------------------------
// fifo_pack_reader
//
// Read-side consumer for the dual-clock FIFO, entirely in the clk_b domain.
// Pops PACK_WORDS consecutive words and presents them as one wide packet.
// A flush pulse emits a partially filled packet early.
//
// Optional feature: define PACK_CHKSUM_EN to add the out_chk port (XOR of the
// valid words of the packet). Without it the port and accumulator are absent.
//
// Ports:
//   clk_b      in   read-domain clock, rising edge
//   rst        in   synchronous active-high reset
//   empty      in   FIFO empty flag
//   dout_b     in   [DATA_W-1:0] FIFO read data, valid the cycle after ren_b
//   ren_b      out  FIFO read enable (combinational, never high while empty)
//   flush      in   single-cycle request to emit the current partial packet
//   out_valid  out  packet valid
//   out_ready  in   downstream accepts packet
//   out_data   out  [DATA_W*PACK_WORDS-1:0] packet, word 0 in the LSBs
//   out_words  out  number of valid words in out_data
//   pkt_count  out  [15:0] accepted packet count, wraps
//   out_chk    out  [DATA_W-1:0] packet checksum (PACK_CHKSUM_EN only)
//   state_dbg  out  FSM state, 0 = FILL, 1 = SEND
//
// Handshake: a packet transfers on a rising clk_b edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, and out_data,
// out_words (and out_chk) hold stable, until that transfer edge.
// -----------------------------------------------------------------------------
module fifo_pack_reader
  import fifo_pack_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int PACK_WORDS = DEF_PACK_WORDS,
  localparam int CNT_W      = $clog2(PACK_WORDS + 1)
) (
  input  logic                         clk_b,
  input  logic                         rst,
  input  logic                         empty,
  input  logic [DATA_W-1:0]            dout_b,
  output logic                         ren_b,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*PACK_WORDS-1:0] out_data,
  output logic [CNT_W-1:0]             out_words,
  output logic [15:0]                  pkt_count,
`ifdef PACK_CHKSUM_EN
  output logic [DATA_W-1:0]            out_chk,
`endif
  output logic                         state_dbg
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACK_WORDS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  pack_state_e       state_q, state_d;
  logic [CNT_W-1:0]  issued_q;    // reads requested for this packet
  logic [CNT_W-1:0]  captured_q;  // words already stored in slots
  logic [CNT_W-1:0]  words_q;     // word count latched for the SEND phase
  logic              rd_pend_q;   // a popped word arrives on dout_b this cycle
  logic              flush_pend_q;
  logic [DATA_W-1:0] slot_q [PACK_WORDS];
  logic [15:0]       pkt_count_q;

  logic handshake;
  logic capture;
  logic last_capture;
  logic flush_service;
  logic flush_emit;

  assign handshake     = (state_q == SEND) && out_ready;
  assign capture       = (state_q == FILL) && rd_pend_q;
  assign last_capture  = capture && (captured_q == LAST_CNT);
  // A flush waits until no read is in flight, so every requested word has
  // landed in a slot before the partial packet is closed.
  assign flush_service = (state_q == FILL) && flush_pend_q && !rd_pend_q;
  assign flush_emit    = flush_service && (captured_q != '0);

  // Next-state and read-enable decode.
  always_comb begin
    state_d = state_q;
    ren_b   = 1'b0;
    case (state_q)
      FILL: begin
        ren_b = !empty && (issued_q < FULL_CNT) && !flush_pend_q && !rst;
        if (last_capture || flush_emit) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q      <= FILL;
      issued_q     <= '0;
      captured_q   <= '0;
      words_q      <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      pkt_count_q  <= '0;
      for (int i = 0; i < PACK_WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_pend_q <= ren_b;

      // A flush seen in the service cycle itself stays pending for later.
      flush_pend_q <= flush || (flush_pend_q && !flush_service);

      if (ren_b) begin
        issued_q <= issued_q + ONE_CNT;
      end

      if (capture) begin
        captured_q <= captured_q + ONE_CNT;
        for (int i = 0; i < PACK_WORDS; i++) begin
          if (captured_q == CNT_W'(i)) begin
            slot_q[i] <= dout_b;
          end
        end
      end

      if (last_capture) begin
        words_q <= FULL_CNT;
      end else if (flush_emit) begin
        words_q <= captured_q;
      end

      // Handshake only occurs in SEND, where no read or capture is active,
      // so clearing here never collides with the updates above.
      if (handshake) begin
        issued_q    <= '0;
        captured_q  <= '0;
        words_q     <= '0;
        pkt_count_q <= pkt_count_q + 16'd1;
        for (int i = 0; i < PACK_WORDS; i++) begin
          slot_q[i] <= '0;
        end
      end
    end
  end

  // Unfilled slots stay at their cleared value, so a flushed packet reads
  // zero above its valid words.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < PACK_WORDS; i++) begin
      out_data[i*DATA_W +: DATA_W] = slot_q[i];
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_words = words_q;
  assign pkt_count = pkt_count_q;
  assign state_dbg = state_q;

`ifdef PACK_CHKSUM_EN
  fifo_pack_chk #(
    .DATA_W(DATA_W)
  ) u_chk (
    .clk_b  (clk_b),
    .rst    (rst),
    .clear  (handshake),
    .capture(capture),
    .word   (dout_b),
    .chk    (out_chk)
  );
`endif

endmodule : fifo_pack_reader

// File: tb/tb_fifo_pack_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pack_reader
//
// Bench for fifo_pack_reader with a behavioural FIFO model. Words pushed into
// the model also build the expected packets, which a monitor pops and compares
// at each handshake.
// -----------------------------------------------------------------------------
module tb_fifo_pack_reader;

  localparam int DATA_W     = 16;
  localparam int PACK_WORDS = 2;
  localparam int CNT_W      = $clog2(PACK_WORDS + 1);
  localparam int PKT_W      = DATA_W * PACK_WORDS;

  // ---------------- clock / reset ----------------
  logic              clk_b = 1'b0;
  logic              rst;
  logic              empty;
  logic [DATA_W-1:0] dout_b;
  logic              ren_b;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PKT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_words;
  logic [15:0]       pkt_count;
  logic              state_dbg;
`ifdef PACK_CHKSUM_EN
  logic [DATA_W-1:0] out_chk;
`endif

  always #5 clk_b = ~clk_b;

  int cyc = 0;
  always @(posedge clk_b) cyc++;

  fifo_pack_reader #(
    .DATA_W    (DATA_W),
    .PACK_WORDS(PACK_WORDS)
  ) dut (
    .clk_b    (clk_b),
    .rst      (rst),
    .empty    (empty),
    .dout_b   (dout_b),
    .ren_b    (ren_b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_words(out_words),
    .pkt_count(pkt_count),
`ifdef PACK_CHKSUM_EN
    .out_chk  (out_chk),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- FIFO model + expected packet builder ----------------
  logic [DATA_W-1:0] fifo_q [$];
  logic [PKT_W-1:0]  exp_q [$];
  logic [CNT_W-1:0]  exp_words_q [$];
  logic [DATA_W-1:0] exp_chk_q [$];

  logic [PKT_W-1:0]  bld_data = '0;
  logic [DATA_W-1:0] bld_chk  = '0;
  int                bld_n    = 0;

  logic stall_en = 1'b0;
  logic toggle   = 1'b0;

  task automatic close_packet();
    exp_q.push_back(bld_data);
    exp_words_q.push_back(CNT_W'(bld_n));
    exp_chk_q.push_back(bld_chk);
    bld_data = '0;
    bld_chk  = '0;
    bld_n    = 0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    bld_data[bld_n*DATA_W +: DATA_W] = w;
    bld_chk = bld_chk ^ w;
    bld_n++;
    if (bld_n == PACK_WORDS) close_packet();
  endtask

  // Expected result of a flush: a partial packet only if words are held.
  task automatic expect_flush();
    if (bld_n > 0) close_packet();
  endtask

  // Empty flag follows occupancy; stall_en forces it high every other cycle.
  always @(negedge clk_b) begin
    toggle = ~toggle;
    empty  = (fifo_q.size() == 0) || (stall_en && toggle);
  end

  always @(posedge clk_b) begin
    if (ren_b) begin
      if (fifo_q.size() == 0) check_val("fifo_underflow", 1, 0);
      else dout_b <= fifo_q.pop_front();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0]      exp_pkt = '0;
  logic             hold_prev = 1'b0;
  logic [PKT_W-1:0] prev_data;
  logic [CNT_W-1:0] prev_words;
  logic             lat_arm = 1'b0;
  int               first_ren = -1;
  int               valid_rise = -1;

  always @(negedge clk_b) begin
    #1;
    if (!rst) begin
      check_val("ren_while_empty", ren_b & empty, 0);
      if (out_valid) check_val("ren_in_send", ren_b, 0);
      if (hold_prev) begin
        check_val("bp_valid", out_valid, 1);
        check_val("bp_data", out_data, prev_data);
        check_val("bp_words", out_words, prev_words);
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_words = out_words;

      if (lat_arm && first_ren < 0 && ren_b) first_ren = cyc;
      if (lat_arm && valid_rise < 0 && out_valid) valid_rise = cyc;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_pkt", out_data, 0);
        end else begin
          logic [PKT_W-1:0]  ed;
          logic [CNT_W-1:0]  ew;
          logic [DATA_W-1:0] ec;
          ed = exp_q.pop_front();
          ew = exp_words_q.pop_front();
          ec = exp_chk_q.pop_front();
          check_val("pkt_data", out_data, ed);
          check_val("pkt_words", out_words, ew);
`ifdef PACK_CHKSUM_EN
          check_val("pkt_chk", out_chk, ec);
`endif
        end
        check_val("pkt_count", pkt_count, exp_pkt);
        exp_pkt = exp_pkt + 16'd1;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_b);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !out_valid)) begin
      tick();
      n++;
      if (n >= budget) begin
        check_val({"timeout_", tag}, 1, 0);
        break;
      end
    end
    tick();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid) begin
      tick();
      n++;
      if (n >= budget) begin
        check_val({"timeout_", tag}, 1, 0);
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PKT_W-1:0] held;
    int               occ;
    int               n;

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    dout_b    = '0;

    // Reset: FIFO holds data, yet nothing may be popped during reset.
    push_word(16'h1111);
    push_word(16'h2222);
    empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_ren", ren_b, 0);
      check_val("rst_valid", out_valid, 0);
      check_val("rst_data", out_data, 0);
      check_val("rst_words", out_words, 0);
      check_val("rst_pkt_count", pkt_count, 0);
`ifdef PACK_CHKSUM_EN
      check_val("rst_chk", out_chk, 0);
`endif
    end
    check_val("rst_no_pop", fifo_q.size(), 2);

    // Basic pack and latency.
    rst     = 1'b0;
    lat_arm = 1'b1;
    wait_drain("basic", 50);
    lat_arm = 1'b0;
    check_val("latency", valid_rise - first_ren, PACK_WORDS + 1);
    check_val("basic_pkt_count", pkt_count, 1);

    // Backpressure: packet held while the FIFO still has words.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i));
    wait_valid("bp_valid", 50);
    held = out_data;
    occ  = fifo_q.size();
    check_val("bp_first_data", held, 32'hA002_A001);
    check_val("bp_occupancy", occ, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_hold_valid", out_valid, 1);
      check_val("bp_hold_data", out_data, held);
      check_val("bp_hold_ren", ren_b, 0);
    end
    check_val("bp_occ_after", fifo_q.size(), occ);
    out_ready = 1'b1;
    wait_drain("bp", 60);

    // Empty toggling mid-fill.
    stall_en = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    wait_drain("stall", 80);
    stall_en = 1'b0;

    // Flush with one captured word.
    push_word(16'hABCD);
    repeat (6) tick();
    check_val("flush_pre_valid", out_valid, 0);
    expect_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush1", 40);

    // Flush with nothing captured: no packet, pending flag drops.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("flush0_valid", out_valid, 0);
    end
    check_val("flush0_pend", dut.flush_pend_q, 0);
    push_word(16'h5555);
    push_word(16'h6666);
    wait_drain("after_flush0", 40);

    // Flush during SEND is held; it then finds nothing captured.
    out_ready = 1'b0;
    push_word(16'h1234);
    push_word(16'h5678);
    wait_valid("send_flush", 40);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_word(16'h7777);
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (8) tick();
    push_word(16'h8888);
    wait_drain("send_flush", 60);

    // Random traffic with random backpressure and empty stalls.
    for (int i = 0; i < 2 * 12; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !out_valid) && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      stall_en  = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    check_val("timeout_random", n >= 2000, 0);
    out_ready = 1'b1;
    stall_en  = 1'b0;
    tick();

    check_val("final_pkt_count", pkt_count, exp_pkt);
    check_val("final_exp_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule : tb_fifo_pack_reader

// File: doc/fifo_pack_reader.md
# fifo_pack_reader

Read-side consumer for the dual-clock 16-bit FIFO, running entirely in the read clock domain (`clk_b`). It pops words from the FIFO through `ren_b` / `dout_b` / `empty` and packs `PACK_WORDS` consecutive words into one wide packet. It presents each packet downstream on a valid/ready handshake. A flush request emits a partially filled packet early, and a packet counter is provided for debug.

## Interface
- `DATA_W`, 16: FIFO word width.
- `PACK_WORDS`, 2: words per packet; legal range 2..8.
- `clk_b`, in, 1: read-domain clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `empty`, in, 1: FIFO empty flag.
- `dout_b`, in, DATA_W: FIFO read data; valid the cycle after a cycle with `ren_b`=1.
- `ren_b`, out, 1: FIFO read enable; combinational; never 1 while `empty`=1.
- `flush`, in, 1: single-cycle request to emit the current partial packet.
- `out_valid`, out, 1: packet valid.
- `out_ready`, in, 1: downstream accepts the packet.
- `out_data`, out, DATA_W*PACK_WORDS: packed packet; word 0 in the least-significant bits.
- `out_words`, out, $clog2(PACK_WORDS+1): number of valid words in `out_data`.
- `pkt_count`, out, 16: count of accepted packets; wraps modulo 2^16.
- `out_chk`, out, DATA_W: packet checksum; this port exists only with `PACK_CHKSUM_EN`.

## Operation
- The FSM has two states: FILL and SEND. Reset state is FILL.
- **FILL state:**
  - `ren_b` = !`empty` && `issued` < PACK_WORDS && !`flush_pend` && !`rst`.
  - `rd_pend` is a registered copy of `ren_b`.
  - When `rd_pend`=1, `dout_b` is written into slot `captured` and `captured` increments.
  - When `captured` reaches PACK_WORDS, the FSM moves to SEND with `out_words`=PACK_WORDS.
- **SEND state:**
  - `out_valid`=1. `ren_b`=0.
  - On `out_valid` && `out_ready`, the FSM returns to FILL. Slots, `issued` and `captured` clear, and `pkt_count` increments.
- **Flush:**
  - `flush` sets `flush_pend`. `flush_pend` is held until it is serviced. A flush arriving during SEND is held for the next FILL.
  - Service happens in FILL when `rd_pend`=0.
    - If `captured`>0: move to SEND with `out_words`=`captured`; unused slots read zero.
    - If `captured`=0: `flush_pend` clears and no packet is produced.
  - `flush_pend` clears on service.
- **Ordering:** words are never dropped or reordered; slot order equals pop order.
- **Backpressure:** while SEND is stalled, no FIFO pops occur, and `out_data` / `out_words` hold stable.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_words`=0, `pkt_count`=0, `out_chk`=0. `ren_b`=0 during every reset cycle.
- **Latency:** with `empty`=0 throughout, `out_valid` rises PACK_WORDS+1 cycles after the first `ren_b` cycle.
- **Read cadence:** `ren_b` is high on PACK_WORDS consecutive cycles.
- **Throughput:** at best one packet per PACK_WORDS+2 cycles; there is no read overlap with SEND.
- **Empty toggling mid-fill:** `ren_b` drops in the same cycle `empty`=1 and resumes when it clears.
- **Reset mid-operation:** a word popped but not yet captured is lost. This is acceptable because `rst` also resets the FIFO.
- **`pkt_count` wrap:** 0xFFFF wraps to 0x0000 on the next accepted packet.

## Configuration
- `PACK_CHKSUM_EN` defined:
  - The `out_chk` port is present.
  - `out_chk` = XOR of all valid words of the packet, accumulated as each word is captured.
  - It is valid together with `out_valid` and clears on handshake.
- `PACK_CHKSUM_EN` undefined:
  - The port, accumulator and logic are absent.
  - All other behaviour is identical.

## Structure
- Package `fifo_pack_pkg`:
  - FSM state enum (FILL, SEND).
  - Default `DATA_W` and `PACK_WORDS` constants.
- Sub-module `fifo_pack_chk`: the XOR accumulator, instantiated only under `PACK_CHKSUM_EN`.
- The counters, slots and FSM stay in the top module.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `empty`=0 → `ren_b`=0 every cycle, and all outputs are zero.
- **Basic pack:** FIFO model supplies 0x1111 then 0x2222 with `out_ready`=1 → `out_data`=0x22221111, `out_words`=2. `out_valid` rises 3 cycles after the first `ren_b`, and `pkt_count`=1 after the handshake.
- **Backpressure:** hold `out_ready`=0 for 10 cycles while the FIFO still holds data → `out_valid` stays 1, `out_data` is stable, and `ren_b`=0 throughout, so FIFO occupancy is unchanged.
- **Empty stall:** `empty` toggles every other cycle while 4 words 0x0001..0x0004 are supplied → `ren_b` is never 1 while `empty`=1. Packets are 0x00020001 then 0x00040003.
- **Flush:** one word 0xABCD followed by a `flush` pulse → `out_data`=0x0000ABCD, `out_words`=1. A flush with 0 words captured → no `out_valid`, and `flush_pend` clears.
- **Checksum (`PACK_CHKSUM_EN`):** words 0x1111 and 0x2222 → `out_chk`=0x3333. For the flushed packet 0xABCD → `out_chk`=0xABCD.
